// File: rtl/vga_scan_generator.sv
// vga_scan_generator: 640x480@60Hz VGA raster timing from a 50 MHz clock.
// A toggling pix_en register forms the 25 MHz pixel clock; counters, sync and
// blank all update together on the edge where the pixel clock falls.
module vga_scan_generator #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

    // Thresholds are 11 bits wide so an end value of 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       pix_en;
    logic [9:0] hc;
    logic [9:0] vc;
    logic [9:0] hc_next;
    logic [9:0] vc_next;
    logic       h_wrap;
    logic       v_wrap;
    logic       hs_next;
    logic       vs_next;
    logic       blank_n_next;
    logic       hs_reg;
    logic       vs_reg;
    logic       blank_n_reg;

    // Next counter position and the sync/blank levels that belong to it.
    always_comb begin
        h_wrap       = (hc == H_MAX);
        v_wrap       = (vc == V_MAX);
        hc_next      = h_wrap ? 10'd0 : hc + 10'd1;
        vc_next      = vc;
        if (h_wrap) begin
            vc_next = v_wrap ? 10'd0 : vc + 10'd1;
        end
        hs_next      = !(({1'b0, hc_next} >= HS_START) && ({1'b0, hc_next} < HS_END));
        vs_next      = !(({1'b0, vc_next} >= VS_START) && ({1'b0, vc_next} < VS_END));
        blank_n_next = ({1'b0, hc_next} < H_VIS_END) && ({1'b0, vc_next} < V_VIS_END);
    end

    // Pixel clock, counters and registered sync/blank; frame_start marks the (0,0) wrap.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pix_en      <= 1'b0;
            hc          <= 10'd0;
            vc          <= 10'd0;
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
            blank_n_reg <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= ~pix_en;
            frame_start <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                hc          <= hc_next;
                vc          <= vc_next;
                hs_reg      <= hs_next;
                vs_reg      <= vs_next;
                blank_n_reg <= blank_n_next;
            end
        end
    end

    assign VGA_CLK     = pix_en;
    assign VGA_HS      = hs_reg;
    assign VGA_VS      = vs_reg;
    assign VGA_BLANK_N = blank_n_reg;
    assign VGA_SYNC_N  = 1'b0;
    assign DrawX       = hc;
    assign DrawY       = vc;

endmodule

// File: tb/tb_vga_scan_generator.sv
// tb_vga_scan_generator: directed checks of the scan generator using a shrunken
// raster (15x8 total) so several whole frames fit in a short run.
module tb_vga_scan_generator;

    localparam int HV = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VV = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int H_TOTAL   = HV + HF + HS + HB;
    localparam int V_TOTAL   = VV + VF + VS + VB;
    localparam int FRAME_PIX = H_TOTAL * V_TOTAL;
    localparam int FRAME_CLK = 2 * FRAME_PIX;

    logic       clk = 1'b0;
    logic       reset;
    logic       vga_clk;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic       frame_start;

    int checks   = 0;
    int failures = 0;

    vga_scan_generator #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .Clk(clk),
        .Reset(reset),
        .VGA_CLK(vga_clk),
        .VGA_HS(vga_hs),
        .VGA_VS(vga_vs),
        .VGA_BLANK_N(vga_blank_n),
        .VGA_SYNC_N(vga_sync_n),
        .DrawX(draw_x),
        .DrawY(draw_y),
        .frame_start(frame_start)
    );

    // 100 MHz-ish simulation clock; rising edge is the active edge.
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compares every output against reset values, or against the position reached
    // t Clk edges after reset release.
    task automatic checkOutput(input int t, input bit in_reset);
        int a, p, hc, vc;
        logic e_clk, e_hs, e_vs, e_bn, e_fs;
        if (in_reset) begin
            hc = 0; vc = 0;
            e_clk = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b1; e_fs = 1'b0;
        end else begin
            a  = t / 2;
            p  = a % FRAME_PIX;
            hc = p % H_TOTAL;
            vc = p / H_TOTAL;
            e_clk = (t % 2) == 1;
            e_hs  = !(hc >= HV + HF && hc < HV + HF + HS);
            e_vs  = !(vc >= VV + VF && vc < VV + VF + VS);
            e_bn  = (hc < HV) && (vc < VV);
            e_fs  = (t > 0) && (t % 2 == 0) && (a % FRAME_PIX == 0);
        end
        checkValue("drawx",   draw_x, 10'(hc));
        checkValue("drawy",   draw_y, 10'(vc));
        checkValue("vga_clk", {9'd0, vga_clk}, {9'd0, e_clk});
        checkValue("hs",      {9'd0, vga_hs}, {9'd0, e_hs});
        checkValue("vs",      {9'd0, vga_vs}, {9'd0, e_vs});
        checkValue("blank_n", {9'd0, vga_blank_n}, {9'd0, e_bn});
        checkValue("frame_start", {9'd0, frame_start}, {9'd0, e_fs});
        checkValue("sync_n",  {9'd0, vga_sync_n}, 10'd0);
    endtask

    task automatic applyStimulus(input logic rst_val);
        @(negedge clk);
        reset = rst_val;
    endtask

    initial begin
        int hs_fall_t, hs_rise_t, vs_low_cnt, fs_first, fs_second, fs_restart;
        logic hs_prev;
        hs_fall_t = -1; hs_rise_t = -1; vs_low_cnt = 0;
        fs_first = -1; fs_second = -1; fs_restart = -1;

        $display("[TB] reset phase");
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput(0, 1'b1);
        end
        reset = 1'b0;

        $display("[TB] two frames from reset plus run to mid-frame point");
        hs_prev = 1'b1;
        for (int t = 1; t <= 2 * FRAME_PIX * 2 + 70; t++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput(t, 1'b0);
            if (t == 2 * H_TOTAL) begin
                checkValue("line_wrap_x", draw_x, 10'd0);
                checkValue("line_wrap_y", draw_y, 10'd1);
            end
            if (hs_prev && !vga_hs && hs_fall_t < 0) begin
                hs_fall_t = t;
                checkValue("hs_fall_x", draw_x, 10'(HV + HF));
            end
            if (!hs_prev && vga_hs && hs_fall_t >= 0 && hs_rise_t < 0) begin
                hs_rise_t = t;
                checkValue("hs_rise_x", draw_x, 10'(HV + HF + HS));
            end
            hs_prev = vga_hs;
            if (t <= FRAME_CLK && !vga_vs) vs_low_cnt++;
            if (frame_start) begin
                if (fs_first < 0) fs_first = t;
                else if (fs_second < 0) fs_second = t;
            end
        end
        checkValue("hs_width_clk", 10'(hs_rise_t - hs_fall_t), 10'(2 * HS));
        checkValue("vs_low_clk",   10'(vs_low_cnt), 10'(2 * VS * H_TOTAL));
        checkValue("fs_first_t",   10'(fs_first), 10'(FRAME_CLK));
        checkValue("fs_interval",  10'(fs_second - fs_first), 10'(FRAME_CLK));
        checkValue("pre_reset_x",  draw_x, 10'd5);
        checkValue("pre_reset_y",  draw_y, 10'd2);

        $display("[TB] mid-frame reset");
        reset = 1'b1;
        #1;
        checkOutput(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput(0, 1'b1);
        reset = 1'b0;

        for (int t = 1; t <= FRAME_CLK + 2; t++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput(t, 1'b0);
            if (frame_start && fs_restart < 0) fs_restart = t;
        end
        checkValue("fs_after_reset", 10'(fs_restart), 10'(FRAME_CLK));

        applyStimulus(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
